// File: rtl/instruction_reg_mw.sv
// Multi-word instruction register: opcode word plus 0..MAX_OPS operand words, bus readback.
// Optional completed-instruction counter enabled by defining IR_INSTR_COUNT_EN.
module instruction_reg_mw #(
   parameter int DATA_W  = 8,
   parameter int OPC_W   = 4,
   parameter int MAX_OPS = 2,
   parameter int CNT_W   = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      ir_in,
   input  logic                      ir_out,
   input  logic                      clear,
   input  logic [CNT_W-1:0]          op_count,
   input  logic [CNT_W-1:0]          op_sel,
   input  logic [DATA_W-1:0]         bus_in,
   output logic [DATA_W-1:0]         q,
   output logic [OPC_W-1:0]          out_control,
   output logic [DATA_W*MAX_OPS-1:0] operands,
   output logic [DATA_W-1:0]         bus_out,
   output logic                      ready,
   output logic                      need_word,
   output logic                      err,
   output logic [15:0]               instr_count
);

   typedef enum logic [1:0] {IDLE, FETCH, READY} state_e;

   state_e                          state_q, state_d;
   logic [DATA_W-1:0]               opc_q;
   logic [MAX_OPS-1:0][DATA_W-1:0]  ops_q;
   logic [CNT_W-1:0]                n_q, idx_q;
   logic [DATA_W-1:0]               bus_q;
   logic                            err_q;

   logic [CNT_W-1:0]                n_load, idx_inc;
   logic                            over_max;
   logic [DATA_W-1:0]               bus_sel;

   assign over_max = (op_count > CNT_W'(MAX_OPS));
   assign n_load   = over_max ? CNT_W'(MAX_OPS) : op_count;
   assign idx_inc  = idx_q + CNT_W'(1);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: each combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else if (ir_in) begin
         case (state_q)
            IDLE, READY: state_d = (n_load == '0) ? READY : FETCH;
            FETCH:       if (idx_inc == n_q) state_d = READY;
            default:     state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      ready     = 1'b0;
      need_word = 1'b0;
      case (state_q)
         FETCH:   need_word = 1'b1;
         READY:   ready     = 1'b1;
         default: ;
      endcase
   end

   // Readback source: legacy low field for single-word instructions, else the selected operand.
   always_comb begin
      bus_sel = '0;
      if (n_q == '0) begin
         bus_sel = {{OPC_W{1'b0}}, opc_q[DATA_W-OPC_W-1:0]};
      end else begin
         for (int k = 0; k < MAX_OPS; k++)
            if (op_sel == CNT_W'(k) && op_sel < n_q) bus_sel = ops_q[k];
      end
   end

   // NOTE: the operand store is a handful of flops, so it is reset like any other register.
   always_ff @(posedge clock) begin
      if (reset) begin
         opc_q <= '0;
         ops_q <= '0;
         n_q   <= '0;
         idx_q <= '0;
         bus_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (ir_out) bus_q <= bus_sel;
         if (clear) begin
            opc_q <= '0;
            ops_q <= '0;
            n_q   <= '0;
            idx_q <= '0;
         end else if (ir_in) begin
            if (state_q == FETCH) begin
               for (int k = 0; k < MAX_OPS; k++)
                  if (idx_q == CNT_W'(k)) ops_q[k] <= bus_in;
               idx_q <= idx_inc;
            end else begin
               opc_q <= bus_in;
               ops_q <= '0;
               n_q   <= n_load;
               idx_q <= '0;
               if (over_max) err_q <= 1'b1;
            end
         end
      end
   end

`ifdef IR_INSTR_COUNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clock) begin
      if (reset)                                     cnt_q <= '0;
      else if (state_d == READY && state_q != READY) cnt_q <= cnt_q + 16'd1;
   end

   assign instr_count = cnt_q;
`else
   assign instr_count = '0;
`endif

   assign q           = opc_q;
   assign out_control = opc_q[DATA_W-1 -: OPC_W];
   assign operands    = ops_q;
   assign bus_out     = bus_q;
   assign err         = err_q;

endmodule
